// File: rtl/instr_fetch.sv
// instr_fetch: fetches instruction words over a req/ack memory handshake into a small
// queue, presents them to decode, and flushes fetched/in-flight words on a branch.
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              branch,
    output logic              pc_step,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ready
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DISCARD = 2'd2;

    logic [1:0] state;
    logic [PW:0] count;
    logic [PW-1:0] rd, wr;
    logic [DATA_W-1:0] data_q [QDEPTH];
    logic [ADDR_W-1:0] addr_q [QDEPTH];
    logic issue, push, pop;

    // Only one request is ever outstanding, so issuing only below FULL cannot overflow.
    always_comb begin
        issue = !reset && state == IDLE && !branch && count != FULL;
        push  = state == WAIT && mem_ack && !branch;
        pop   = inst_valid && inst_ready;
    end

    assign pc_step    = issue;
    assign mem_req    = state != IDLE;
    assign inst_valid = count != '0;
    assign inst_data  = data_q[rd];
    assign inst_addr  = addr_q[rd];

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr] <= mem_rdata;
            addr_q[wr] <= mem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            rd       <= '0;
            wr       <= '0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    state    <= WAIT;
                    mem_addr <= pc_addr;
                end
                WAIT:    state <= mem_ack ? IDLE : (branch ? DISCARD : WAIT);
                DISCARD: state <= mem_ack ? IDLE : DISCARD;
                default: state <= IDLE;
            endcase
            // A branch flush overrides any pop or push in the same cycle.
            if (branch) begin
                count <= '0;
                rd    <= wr;
            end else begin
                wr    <= push ? wr + 1'b1 : wr;
                rd    <= pop ? rd + 1'b1 : rd;
                count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed checks of instr_fetch against a transaction-level
// model (outstanding request + expected instruction queue + PC + latency-driven memory).
module tb_instr_fetch;
    localparam int QD = 2;
    logic clk = 0, reset = 1, branch = 0, mem_ack = 0, inst_ready = 0;
    logic pc_step, mem_req, inst_valid;
    logic [7:0] pc_addr = 0, mem_addr, inst_addr;
    logic [15:0] mem_rdata = 0, inst_data;

    instr_fetch dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr), .branch(branch), .pc_step(pc_step),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_addr(inst_addr),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [7:0] pc = 8'h10, req_addr = 0;
    bit out = 0, stale = 0, stray = 0;
    int age = 0, lat = 0, min_lat = 0, max_lat = 0, steps = 0;
    logic [23:0] q[$];
    logic [23:0] deliv[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit br, input logic [7:0] tgt, input bit rdy);
        bit es, pop, ack;
        @(negedge clk);
        reset = rst; branch = br; inst_ready = rdy; pc_addr = pc;
        ack = (out && age >= lat) || stray;
        mem_ack = ack;
        mem_rdata = {8'hA0, req_addr};
        #1;
        es = !rst && !out && !br && q.size() < QD;
        chk("pc_step", pc_step, es);
        chk("mem_req", mem_req, out);
        if (out) chk("mem_addr", mem_addr, req_addr);
        chk("inst_valid", inst_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("inst_addr", inst_addr, q[0][23:16]);
            chk("inst_data", inst_data, q[0][15:0]);
        end
        steps += int'(pc_step);
        pop = !rst && q.size() != 0 && rdy;
        if (pop && !br) deliv.push_back({inst_addr, inst_data});
        @(posedge clk);
        if (rst) begin
            out = 0;
            q.delete();
        end else begin
            if (br) q.delete();
            else if (pop) void'(q.pop_front());
            if (out) begin
                if (ack) begin
                    out = 0;
                    if (!stale && !br) q.push_back({req_addr, 8'hA0, req_addr});
                end else begin
                    if (br) stale = 1;
                    age++;
                end
            end else if (es) begin
                out = 1; stale = 0; req_addr = pc; age = 0;
                lat = $urandom_range(max_lat, min_lat);
            end
        end
        if (br) pc = tgt;
        else if (es) pc = pc + 8'd1;
    endtask

    initial begin
        // Basic in-order fetch from 0x10 with zero-wait memory
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1);
        chk("s1_count", deliv.size() >= 3, 1);
        for (int i = 0; i < 3 && i < deliv.size(); i++)
            chk("s1_word", deliv[i], {8'(8'h10 + i), 16'(16'hA010 + i)});

        // Full queue stalls issue; a single pop frees exactly one issue
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        steps = 0;
        deliv.delete();
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        chk("stall_steps", steps, 0);
        chk("stall_valid", inst_valid, 1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        chk("one_pop", deliv.size(), 1);
        chk("one_issue", steps, 1);

        // Branch while waiting on a slow memory; stale word discarded
        min_lat = 2; max_lat = 2;
        for (int i = 0; i < 20 && !(out && age == 0); i++) cycle(0, 0, 0, 1);
        chk("s3_wait", out && age == 0, 1);
        cycle(0, 1, 8'h40, 1);
        deliv.delete();
        for (int i = 0; i < 14; i++) cycle(0, 0, 0, 1);
        chk("s3_count", deliv.size() >= 1, 1);
        if (deliv.size() >= 1) chk("s3_first", deliv[0], {8'h40, 16'hA040});

        // Branch coinciding with mem_ack while one queued entry pops
        min_lat = 0; max_lat = 0;
        for (int i = 0; i < 20 && !(out && q.size() == 1); i++) cycle(0, 0, 0, q.size() > 1);
        chk("s4_setup", out && q.size() == 1, 1);
        deliv.delete();
        cycle(0, 1, 8'h80, 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);
        chk("s4_nopop", deliv.size() >= 1, 1);
        if (deliv.size() >= 1) chk("s4_first", deliv[0], {8'h80, 16'hA080});

        // Push and pop together at count 1 across pointer wrap
        for (int i = 0; i < 20 && !(q.size() == 1 && out); i++) cycle(0, 0, 0, q.size() > 1);
        deliv.delete();
        for (int i = 0; i < 24; i++) cycle(0, 0, 0, out && age >= lat);
        chk("s5_count", deliv.size() >= 8, 1);
        for (int i = 1; i < deliv.size(); i++) begin
            chk("s5_order", deliv[i][23:16], 8'(deliv[i-1][23:16] + 8'd1));
            chk("s5_data", deliv[i][15:0], {8'hA0, deliv[i][23:16]});
        end

        // Reset mid-request, then a late ack in IDLE must be ignored
        min_lat = 5; max_lat = 5;
        for (int i = 0; i < 20 && !out; i++) cycle(0, 0, 0, 1);
        chk("s6_req", out, 1);
        cycle(1, 0, 0, 0);
        stray = 1;
        cycle(0, 0, 0, 0);
        stray = 0;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

        // Randomized traffic
        min_lat = 0; max_lat = 3;
        for (int i = 0; i < 500; i++)
            cycle($urandom_range(63) == 0, $urandom_range(11) == 0, 8'($urandom), $urandom_range(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
